// File: rtl/ram256_arbiter_if.sv
// Bus bundle for ram256_arbiter: two requester ports, the RAM port and the grant.
// The arbiter connects through the slave modport. The requesters and the RAM
// connect through the master modport.
interface ram256_arbiter_if;
  logic        aReq;
  logic        aWe;
  logic [7:0]  aAddress;
  logic [15:0] aIn;
  logic        aAck;
  logic [15:0] aOut;

  logic        bReq;
  logic        bWe;
  logic [7:0]  bAddress;
  logic [15:0] bIn;
  logic        bAck;
  logic [15:0] bOut;

  logic        ramLoad;
  logic [7:0]  ramAddress;
  logic [15:0] ramIn;
  logic [15:0] ramOut;

  logic [1:0]  grant;

  modport slave (
    input  aReq, aWe, aAddress, aIn,
    output aAck, aOut,
    input  bReq, bWe, bAddress, bIn,
    output bAck, bOut,
    output ramLoad, ramAddress, ramIn,
    input  ramOut,
    output grant
  );

  modport master (
    output aReq, aWe, aAddress, aIn,
    input  aAck, aOut,
    output bReq, bWe, bAddress, bIn,
    input  bAck, bOut,
    input  ramLoad, ramAddress, ramIn,
    output ramOut,
    input  grant
  );
endinterface

// File: rtl/ram256_arbiter.sv
// ram256_arbiter: shares one 256x16 RAM port between requesters A and B.
// Each grant runs IDLE -> ACCESS -> DONE, so every access takes three cycles.
// The RAM access happens in ACCESS. The one-cycle ACK is issued in DONE.
// Read data is held per requester, so each requester keeps stable data after its ACK.
// Optional feature: define RAM256_ARBITER_ROUND_ROBIN_EN to resolve ties
// round-robin. Without it, ties resolve with fixed priority, and A wins.
module ram256_arbiter (
  input  logic                    clk,
  input  logic                    rst,
  ram256_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        cmdWe_q, cmdWe_d;
  logic [7:0]  cmdAddr_q, cmdAddr_d;
  logic [15:0] cmdData_q, cmdData_d;
  logic [15:0] aOut_q, aOut_d;
  logic [15:0] bOut_q, bOut_d;
  logic        pickB;

`ifdef RAM256_ARBITER_ROUND_ROBIN_EN
  logic        rrLastB_q, rrLastB_d;

  // Tie-break: give the grant to the port that did not win most recently.
  always_comb begin
    pickB = bus.bReq && (!bus.aReq || !rrLastB_q);
  end

  // Round-robin pointer; resets to "B last" so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rrLastB_q <= 1'b1;
    else     rrLastB_q <= rrLastB_d;
  end
`else
  // Fixed priority: B wins only when A is not requesting.
  always_comb begin
    pickB = bus.bReq && !bus.aReq;
  end
`endif

  // State and datapath registers; an async reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      cmdWe_q   <= 1'b0;
      cmdAddr_q <= 8'h00;
      cmdData_q <= 16'h0000;
      aOut_q    <= 16'h0000;
      bOut_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cmdWe_q   <= cmdWe_d;
      cmdAddr_q <= cmdAddr_d;
      cmdData_q <= cmdData_d;
      aOut_q    <= aOut_d;
      bOut_q    <= bOut_d;
    end
  end

  // Next state: latch the winner's command in IDLE, capture read data in
  // ACCESS, and release the grant after DONE.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cmdWe_d   = cmdWe_q;
    cmdAddr_d = cmdAddr_q;
    cmdData_d = cmdData_q;
    aOut_d    = aOut_q;
    bOut_d    = bOut_q;
`ifdef RAM256_ARBITER_ROUND_ROBIN_EN
    rrLastB_d = rrLastB_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.aReq || bus.bReq) begin
          state_d = ACCESS;
          if (pickB) begin
            grant_d   = 2'b10;
            cmdWe_d   = bus.bWe;
            cmdAddr_d = bus.bAddress;
            cmdData_d = bus.bIn;
          end else begin
            grant_d   = 2'b01;
            cmdWe_d   = bus.aWe;
            cmdAddr_d = bus.aAddress;
            cmdData_d = bus.aIn;
          end
`ifdef RAM256_ARBITER_ROUND_ROBIN_EN
          rrLastB_d = pickB;
`endif
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!cmdWe_q) begin
          if (grant_q[0]) aOut_d = bus.ramOut;
          if (grant_q[1]) bOut_d = bus.ramOut;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Outputs: the RAM port only carries the latched winner's command, and the write strobe only fires in ACCESS.
  always_comb begin
    bus.ramLoad    = (state_q == ACCESS) && cmdWe_q;
    bus.ramAddress = cmdAddr_q;
    bus.ramIn      = cmdData_q;
    bus.aAck       = (state_q == DONE) && grant_q[0];
    bus.bAck       = (state_q == DONE) && grant_q[1];
    bus.aOut       = aOut_q;
    bus.bOut       = bOut_q;
    bus.grant      = grant_q;
  end

endmodule

// File: tb/tb_ram256_arbiter.sv
// Directed self-checking bench for ram256_arbiter, with a behavioural 256x16 RAM.
// Expected tie-break results follow RAM256_ARBITER_ROUND_ROBIN_EN.
module tb_ram256_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [256];
  logic        pokeEn;
  logic [7:0]  pokeAddr;
  logic [15:0] pokeData;

  ram256_arbiter_if bus ();

  ram256_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: combinational read, write on the rising edge; pokes preload it.
  assign bus.ramOut = mem[bus.ramAddress];
  always @(posedge clk) begin
    if (bus.ramLoad) mem[bus.ramAddress] <= bus.ramIn;
    else if (pokeEn) mem[pokeAddr] <= pokeData;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic isB, input logic req, input logic we,
                               input logic [7:0] addr, input logic [15:0] data);
    if (isB) begin
      bus.bReq = req; bus.bWe = we; bus.bAddress = addr; bus.bIn = data;
    end else begin
      bus.aReq = req; bus.aWe = we; bus.aAddress = addr; bus.aIn = data;
    end
  endtask

  task automatic poke(input logic [7:0] addr, input logic [15:0] data);
    pokeEn = 1'b1; pokeAddr = addr; pokeData = data;
    tick();
    pokeEn = 1'b0;
  endtask

  initial begin
    int aAcks;
    int bAcks;
    logic [3:0] seq;
    int loads;
    int firstLoad;
    int secondLoad;

    rst = 1'b1;
    pokeEn = 1'b0; pokeAddr = 8'h00; pokeData = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Preload the RAM while the arbiter is held in reset.
    poke(8'h01, 16'h0001);
    poke(8'h02, 16'h0002);
    poke(8'h20, 16'h5555);

    checkOutput("reset aAck", {15'd0, bus.aAck}, 16'd0);
    checkOutput("reset bAck", {15'd0, bus.bAck}, 16'd0);
    checkOutput("reset aOut", bus.aOut, 16'h0000);
    checkOutput("reset bOut", bus.bOut, 16'h0000);
    checkOutput("reset ramLoad", {15'd0, bus.ramLoad}, 16'd0);
    checkOutput("reset ramAddress", {8'd0, bus.ramAddress}, 16'h0000);
    checkOutput("reset ramIn", bus.ramIn, 16'h0000);
    checkOutput("reset grant", {14'd0, bus.grant}, 16'd0);

    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] A write BEEF @10");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    tick();
    checkOutput("wr access grant", {14'd0, bus.grant}, 16'h0001);
    checkOutput("wr access ramLoad", {15'd0, bus.ramLoad}, 16'd1);
    checkOutput("wr access ramAddress", {8'd0, bus.ramAddress}, 16'h0010);
    checkOutput("wr access ramIn", bus.ramIn, 16'hBEEF);
    checkOutput("wr access aAck", {15'd0, bus.aAck}, 16'd0);
    tick();
    checkOutput("wr done aAck", {15'd0, bus.aAck}, 16'd1);
    checkOutput("wr done ramLoad", {15'd0, bus.ramLoad}, 16'd0);
    checkOutput("wr done grant", {14'd0, bus.grant}, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
    tick();
    checkOutput("wr idle aAck", {15'd0, bus.aAck}, 16'd0);
    checkOutput("wr idle grant", {14'd0, bus.grant}, 16'd0);
    checkOutput("wr ram content", mem[8'h10], 16'hBEEF);

    $display("[TB] A read @10");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    checkOutput("rd access ramLoad", {15'd0, bus.ramLoad}, 16'd0);
    tick();
    checkOutput("rd done aAck", {15'd0, bus.aAck}, 16'd1);
    checkOutput("rd done aOut", bus.aOut, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();

    $display("[TB] B read @10");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    checkOutput("b access grant", {14'd0, bus.grant}, 16'h0002);
    tick();
    checkOutput("b done bAck", {15'd0, bus.bAck}, 16'd1);
    checkOutput("b done aAck", {15'd0, bus.aAck}, 16'd0);
    checkOutput("b done bOut", bus.bOut, 16'hBEEF);
    checkOutput("b done aOut kept", bus.aOut, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();

    $display("[TB] simultaneous reads A@01 B@02");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 16'h0000);
    tick();
    checkOutput("tie grant c1", {14'd0, bus.grant}, 16'h0001);
    tick();
    checkOutput("tie grant c2", {14'd0, bus.grant}, 16'h0001);
    checkOutput("tie aAck", {15'd0, bus.aAck}, 16'd1);
    checkOutput("tie aOut", bus.aOut, 16'h0001);
    checkOutput("tie bAck early", {15'd0, bus.bAck}, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    checkOutput("tie grant c3", {14'd0, bus.grant}, 16'h0000);
    tick();
    checkOutput("tie grant c4", {14'd0, bus.grant}, 16'h0002);
    tick();
    checkOutput("tie grant c5", {14'd0, bus.grant}, 16'h0002);
    checkOutput("tie bAck", {15'd0, bus.bAck}, 16'd1);
    checkOutput("tie bOut", bus.bOut, 16'h0002);
    checkOutput("tie aOut kept", bus.aOut, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();

    $display("[TB] continuous requests for 12 cycles");
    aAcks = 0; bAcks = 0; seq = 4'b0000;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 16'h0000);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.aAck) begin
        aAcks++;
        seq = {seq[2:0], 1'b0};
        checkOutput("stream aOut", bus.aOut, 16'h0001);
      end
      if (bus.bAck) begin
        bAcks++;
        seq = {seq[2:0], 1'b1};
        checkOutput("stream bOut", bus.bOut, 16'h0002);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
`ifdef RAM256_ARBITER_ROUND_ROBIN_EN
    checkOutput("stream aAcks", aAcks[15:0], 16'd2);
    checkOutput("stream bAcks", bAcks[15:0], 16'd2);
    checkOutput("stream order", {12'd0, seq}, 16'b0101);
`else
    checkOutput("stream aAcks", aAcks[15:0], 16'd4);
    checkOutput("stream bAcks", bAcks[15:0], 16'd0);
    checkOutput("stream order", {12'd0, seq}, 16'b0000);
`endif
    tick();
    tick();

    $display("[TB] reset during A write 1234 @20");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h20, 16'h1234);
    tick();
    checkOutput("abort ramLoad before", {15'd0, bus.ramLoad}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort ramLoad", {15'd0, bus.ramLoad}, 16'd0);
    checkOutput("abort ramAddress", {8'd0, bus.ramAddress}, 16'h0000);
    checkOutput("abort ramIn", bus.ramIn, 16'h0000);
    checkOutput("abort grant", {14'd0, bus.grant}, 16'd0);
    checkOutput("abort aAck", {15'd0, bus.aAck}, 16'd0);
    checkOutput("abort aOut", bus.aOut, 16'h0000);
    checkOutput("abort bOut", bus.bOut, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("abort no ack 1", {15'd0, bus.aAck}, 16'd0);
    tick();
    checkOutput("abort no ack 2", {15'd0, bus.aAck}, 16'd0);
    checkOutput("abort ram kept", mem[8'h20], 16'h5555);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    tick();
    tick();
    checkOutput("abort readback ack", {15'd0, bus.aAck}, 16'd1);
    checkOutput("abort readback", bus.aOut, 16'h5555);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();

    $display("[TB] A write CAFE @30 with REQ held after ACK");
    loads = 0; firstLoad = 0; secondLoad = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 16'hCAFE);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ramLoad) begin
        loads++;
        if (loads == 1) firstLoad = i;
        if (loads == 2) secondLoad = i;
      end
      if (i == 5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    checkOutput("held load count", loads[15:0], 16'd2);
    checkOutput("held first load", firstLoad[15:0], 16'd1);
    checkOutput("held second load", secondLoad[15:0], 16'd4);
    checkOutput("held ram content", mem[8'h30], 16'hCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram256_arbiter.md
# ram256_arbiter

Two-port access arbiter in front of the 256 x 16-bit block RAM. It lets two requesters share the single RAM port, for example the CPU data path (port A) and a display/DMA engine (port B). It uses a REQ/ACK handshake, arbitrates between them, and sequences exactly one RAM access per grant. The read data is registered per requester, so each requester sees stable data after its ACK.

## Interface
- No parameters; geometry fixed at 256 words x 16 bits.
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- A_REQ  in  1  port A request; held high until A_ACK
- A_WE  in  1  port A write enable (1 = write, 0 = read)
- A_ADDRESS  in  8  port A word address
- A_IN  in  16  port A write data
- A_ACK  out  1  one-cycle completion pulse for port A
- A_OUT  out  16  port A read data, registered
- B_REQ, B_WE, B_ADDRESS, B_IN, B_ACK, B_OUT: same as port A, for port B
- RAM_LOAD  out  1  RAM write strobe
- RAM_ADDRESS  out  8  RAM address
- RAM_IN  out  16  RAM write data
- RAM_OUT  in  16  RAM read data, combinational from RAM_ADDRESS
- GRANT  out  2  one-hot current owner {B,A}; 2'b00 when idle

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - If any REQ is high, pick a winner.
  - Latch the winner's WE, ADDRESS and IN into command registers.
  - Set GRANT for the winner and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - RAM_ADDRESS and RAM_IN come from the command registers.
  - RAM_LOAD = latched WE.
  - On a read, the winner's X_OUT <= RAM_OUT at the end of the cycle.
  - On a write, X_OUT is unchanged.
  - Go to DONE.
- **DONE**
  - The winner's X_ACK is high for this cycle only.
  - GRANT stays set.
  - Go to IDLE.
- **Arbitration**
  - A single requester always wins.
  - When A_REQ and B_REQ are both high, the winner depends on the configuration (see Configuration).
- **Handshake**
  - The requester must hold REQ, WE, ADDRESS and IN stable from REQ assertion until it sees ACK.
  - REQ is ignored in ACCESS and DONE.
  - If REQ is still high in the IDLE cycle after ACK, it is treated as a new transaction.
- The loser's ACK stays 0, its OUT is not modified, and its request stays pending.
- RAM_LOAD is never asserted outside ACCESS.
- The loser's inputs never reach the RAM_* outputs.

## Timing
- Reset values:
  - state = IDLE
  - A_ACK = B_ACK = 0, A_OUT = B_OUT = 16'h0000
  - RAM_LOAD = 0, RAM_ADDRESS = 8'h00, RAM_IN = 16'h0000
  - GRANT = 2'b00
  - round-robin pointer = "last granted B", so A wins the first tie
- Latency: REQ sampled high at IDLE edge N → ACCESS in cycle N+1 → ACK high in cycle N+2, with X_OUT already valid in that cycle.
- Throughput is one access per 3 cycles, including IDLE.
- A waiting loser is served by cycle N+5 at the latest (its ACK in N+5).
- A write commits at the rising edge ending ACCESS.
- A read issued after an ACKed write to the same address returns the new data.
- Asynchronous reset mid-operation:
  - All outputs drop to their reset values immediately, including RAM_LOAD.
  - An ACCESS-cycle write is lost if RESET rises before the committing edge.
  - No ACK is issued for an aborted transaction.
- REQ deasserted before ACK is a protocol violation. The arbiter completes the latched transaction anyway.

## Configuration
- Macro: `RAM256_ARBITER_ROUND_ROBIN_EN`
- **Defined**:
  - On a tie, grant the port not granted most recently.
  - The pointer updates on every grant.
- **Undefined**:
  - Fixed priority: A always wins ties.
  - B can be starved while A requests continuously.
  - The pointer register is not built.

## Test plan
- Reset, then A write 16'hBEEF @ 8'h10:
  - A_ACK pulses one cycle, two cycles after the grant edge.
  - RAM_LOAD is high for exactly one cycle with RAM_ADDRESS = 8'h10.
  - Then A read @ 8'h10 → A_OUT = 16'hBEEF at A_ACK.
- B read @ 8'h10 while A idle → B_OUT = 16'hBEEF, and A_OUT unchanged.
- A and B both request reads @ 8'h01 and 8'h02 (preloaded 16'h0001, 16'h0002) in the same cycle:
  - A is served first: A_ACK, then B_ACK three cycles later.
  - Outputs are correct and GRANT sequence is 01, 01, 00, 10, 10.
- A and B both hold REQ continuously for 12 cycles:
  - With the macro, grants alternate A, B, A, B.
  - Without the macro, only A is granted and B_ACK stays 0.
- Assert RESET during ACCESS of an A write of 16'h1234 @ 8'h20:
  - RAM_LOAD falls immediately, no A_ACK is issued, all outputs take reset values.
  - A later read @ 8'h20 returns the old value.
- A write with A_REQ held high after ACK:
  - A second write is issued in the following IDLE.
  - Exactly two RAM_LOAD pulses, three cycles apart.
